// File: rtl/frame_stream_feeder.sv
// Pixel stream feeder: 2-entry skid buffer from a valid/ready source into a write/full FIFO,
// with column/row/image tracking, frame sideband and optional per-image ack pacing.
module frame_stream_feeder #(
  parameter int DWIDTH  = 32,
  parameter int NUM_CH  = 3,
  parameter int WIDTH   = 224,
  parameter int HEIGHT  = 224,
  parameter int NUM_IMG = 1,
  parameter int MODE    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*DWIDTH-1:0] s_data,
  input  logic                     fifo_full,
  output logic                     fifo_wrreq,
  output logic [NUM_CH*DWIDTH-1:0] fifo_data,
  output logic                     sof,
  output logic                     eol,
  output logic                     eof,
  input  logic                     img_ack,
  output logic                     busy,
  output logic                     done,
  output logic                     ack_ovf,
  output logic [1:0]               dbg_state
);

  localparam int DW  = NUM_CH * DWIDTH;
  localparam int PIX = WIDTH * HEIGHT;
  localparam int ICW = $clog2(PIX + 1);
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int IW  = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [IW-1:0]  IMG_LAST = IW'(NUM_IMG - 1);
  localparam logic [ICW-1:0] PIX_N    = ICW'(PIX);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t         state_q;
  logic [1:0]     occ_q, occ_d;
  logic [DW-1:0]  ent0_q, ent0_d, ent1_q, ent1_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [IW-1:0]  img_q, img_d;
  logic           credit_q, done_q, ack_ovf_q;

  logic push, pop, col_last, row_last, img_last, restart, ack_in;

  // Handshake: a beat transfers on any rising edge where s_valid && s_ready; the source must
  // hold s_data stable while s_valid is high and s_ready is low. Downstream, a word is written
  // on every edge where fifo_wrreq is high, and fifo_wrreq is never raised while fifo_full.
  assign s_ready    = (state_q == S_RUN) && (occ_q != 2'd2) && (in_cnt_q < PIX_N);
  assign push       = s_valid && s_ready;
  assign fifo_wrreq = (occ_q != 2'd0) && !fifo_full;
  assign pop        = fifo_wrreq;
  assign fifo_data  = (occ_q != 2'd0) ? ent0_q : '0;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign img_last = (img_q == IMG_LAST);
  assign sof      = pop && (col_q == '0) && (row_q == '0);
  assign eol      = pop && col_last;
  assign eof      = eol && row_last;

  assign restart   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign ack_in    = (MODE == 1) && img_ack;
  assign busy      = (state_q == S_RUN) || (state_q == S_WAIT_ACK);
  assign done      = done_q;
  assign ack_ovf   = ack_ovf_q;
  assign dbg_state = state_q;

  // Entry 0 is always the head; a simultaneous push and pop can only happen at occupancy 1.
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = s_data;
        else               ent1_d = s_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: ent0_d = s_data;
      default: ;
    endcase
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    img_d    = img_q;
    in_cnt_d = eof ? '0 : in_cnt_q + ICW'(push);
    if (pop) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d = '0;
          img_d = img_last ? '0 : img_q + IW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      occ_q     <= 2'd0;
      ent0_q    <= '0;
      ent1_q    <= '0;
      in_cnt_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      img_q     <= '0;
      credit_q  <= 1'b0;
      done_q    <= 1'b0;
      ack_ovf_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      if (restart) begin
        state_q   <= S_RUN;
        in_cnt_q  <= '0;
        col_q     <= '0;
        row_q     <= '0;
        img_q     <= '0;
        credit_q  <= 1'b0;
        done_q    <= 1'b0;
        ack_ovf_q <= 1'b0;
      end else begin
        in_cnt_q <= in_cnt_d;
        col_q    <= col_d;
        row_q    <= row_d;
        img_q    <= img_d;
        case (state_q)
          S_RUN: begin
            if (ack_in) begin
              credit_q <= 1'b1;
              if (credit_q) ack_ovf_q <= 1'b1;
            end
            if (eof) begin
              if (img_last) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else if (MODE == 1) begin
                // An ack landing on the eof edge counts as credit for this boundary.
                if (credit_q || ack_in) credit_q <= credit_q && ack_in;
                else                    state_q  <= S_WAIT_ACK;
              end
            end
          end
          S_WAIT_ACK: begin
            if (ack_in) state_q <= S_RUN;
          end
          default: begin
            if (ack_in) begin
              credit_q <= 1'b1;
              if (credit_q) ack_ovf_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_feeder.sv
// Scoreboard bench for frame_stream_feeder: three instances cover the single-image free-run,
// two-image ack-paced and 1x1-frame configurations.
module tb_frame_stream_feeder;

  localparam int PW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]         rst, start, s_valid, s_ready, fifo_full, fifo_wrreq;
  logic [2:0]         sof, eol, eof, img_ack, busy, done, ack_ovf;
  logic [2:0][PW-1:0] s_data, fifo_data;
  logic [2:0][1:0]    state;

  logic [26:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt[3] = '{0, 0, 0};
  int last_wr_cyc[3] = '{0, 0, 0};
  int first_acc_cyc = 0;
  bit abort_drv = 1'b0;

  frame_stream_feeder #(.DWIDTH(8), .NUM_CH(3), .WIDTH(4), .HEIGHT(2), .NUM_IMG(1), .MODE(0)) u_a (
    .clk(clk), .reset(rst[0]), .start(start[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .fifo_full(fifo_full[0]), .fifo_wrreq(fifo_wrreq[0]),
    .fifo_data(fifo_data[0]), .sof(sof[0]), .eol(eol[0]), .eof(eof[0]), .img_ack(img_ack[0]),
    .busy(busy[0]), .done(done[0]), .ack_ovf(ack_ovf[0]), .dbg_state(state[0])
  );

  frame_stream_feeder #(.DWIDTH(8), .NUM_CH(3), .WIDTH(4), .HEIGHT(2), .NUM_IMG(2), .MODE(1)) u_b (
    .clk(clk), .reset(rst[1]), .start(start[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .fifo_full(fifo_full[1]), .fifo_wrreq(fifo_wrreq[1]),
    .fifo_data(fifo_data[1]), .sof(sof[1]), .eol(eol[1]), .eof(eof[1]), .img_ack(img_ack[1]),
    .busy(busy[1]), .done(done[1]), .ack_ovf(ack_ovf[1]), .dbg_state(state[1])
  );

  frame_stream_feeder #(.DWIDTH(8), .NUM_CH(3), .WIDTH(1), .HEIGHT(1), .NUM_IMG(3), .MODE(0)) u_c (
    .clk(clk), .reset(rst[2]), .start(start[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .s_data(s_data[2]), .fifo_full(fifo_full[2]), .fifo_wrreq(fifo_wrreq[2]),
    .fifo_data(fifo_data[2]), .sof(sof[2]), .eol(eol[2]), .eof(eof[2]), .img_ack(img_ack[2]),
    .busy(busy[2]), .done(done[2]), .ack_ovf(ack_ovf[2]), .dbg_state(state[2])
  );

  function automatic logic [PW-1:0] pix(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b ^ 8'hA5, b + 8'd64, b};
  endfunction

  // Expected write: {sof, eol, eof, data} for beat k of a w x h frame sequence.
  function automatic logic [26:0] exp_beat(input int k, input int w, input int h);
    logic s, e, f;
    s = ((k % (w * h)) == 0);
    e = ((k % w) == (w - 1));
    f = ((k % (w * h)) == (w * h - 1));
    return {s, e, f, pix(k)};
  endfunction

  function automatic logic [63:0] outs(input int i);
    return 64'({s_ready[i], fifo_wrreq[i], sof[i], eol[i], eof[i], busy[i], done[i], ack_ovf[i],
                state[i], fifo_data[i]});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask

  task automatic pulse_ack(input int i);
    @(posedge clk); #1 img_ack[i] = 1'b1;
    @(posedge clk); #1 img_ack[i] = 1'b0;
  endtask

  task automatic wait_writes(input int i, input int n);
    int t;
    t = 0;
    while (wr_cnt[i] < n && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    if (wr_cnt[i] < n) begin
      n_chk++;
      $display("FAIL write_timeout u%0d: got %0d writes, required %0d", i, wr_cnt[i], n);
    end
  endtask

  task automatic drive(input int i, input int n, input int w, input int h);
    for (int k = 0; k < n; k++) begin
      logic acc;
      int waited;
      acc = 1'b0;
      waited = 0;
      s_valid[i] = 1'b1;
      s_data[i]  = pix(k);
      while (!acc) begin
        @(negedge clk);
        acc = s_ready[i];
        @(posedge clk); #1;
        if (acc) begin
          exp_q.push_back(exp_beat(k, w, h));
          if (k == 0) first_acc_cyc = cyc;
        end else if (abort_drv) begin
          s_valid[i] = 1'b0;
          return;
        end else begin
          waited++;
          if (waited > 60) begin
            n_chk++;
            $display("FAIL accept_timeout u%0d: beat %0d not accepted, required within 60 cycles", i, k);
            s_valid[i] = 1'b0;
            return;
          end
        end
      end
    end
    s_valid[i] = 1'b0;
  endtask

  // Monitor: every presented write pops one expected entry.
  initial begin
    logic [26:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (fifo_wrreq[i] === 1'b1) begin
          wr_cnt[i]++;
          last_wr_cyc[i] = cyc;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write u%0d: data 0x%0h written, no write expected", i, fifo_data[i]);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("write_u%0d_n%0d", i, wr_cnt[i]),
                64'({sof[i], eol[i], eof[i], fifo_data[i]}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, first_wr, ack_cyc, eof_cyc;
    rst = '1; start = '0; s_valid = '0; s_data = '0; fifo_full = '0; img_ack = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_outputs_u%0d", i), outs(i), 64'd0);
    rst = '0;
    @(posedge clk); #1;

    // T1: free-running single image, one write per cycle
    base = wr_cnt[0];
    pulse_start(0);
    fork
      drive(0, 8, 4, 2);
      begin
        wait_writes(0, base + 1);
        first_wr = last_wr_cyc[0];
        chk("t1_first_write_latency", 64'(first_wr - first_acc_cyc + 1), 64'd1);
        wait_writes(0, base + 8);
        chk("t1_back_to_back", 64'(last_wr_cyc[0] - first_wr), 64'd7);
        chk("t1_done_not_busy", 64'({done[0], busy[0]}), 64'b10);
      end
    join
    chk("t1_queue_drained", 64'(exp_q.size()), 64'd0);

    // T2: downstream full for four cycles
    base = wr_cnt[0];
    pulse_start(0);
    fork
      drive(0, 8, 4, 2);
      begin
        @(posedge clk);
        @(posedge clk); #1 fifo_full[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        chk("t2_ready_and_wrreq_low", 64'({s_ready[0], fifo_wrreq[0]}), 64'd0);
        chk("t2_head_held", 64'(fifo_data[0]), 64'(pix(1)));
        @(posedge clk);
        @(posedge clk); #1 fifo_full[0] = 1'b0;
        wait_writes(0, base + 8);
        chk("t2_done", 64'(done[0]), 64'd1);
      end
    join
    chk("t2_write_count", 64'(wr_cnt[0] - base), 64'd8);
    chk("t2_queue_drained", 64'(exp_q.size()), 64'd0);

    // T3: ack-paced, two images
    base = wr_cnt[1];
    pulse_start(1);
    fork
      drive(1, 16, 4, 2);
      begin
        wait_writes(1, base + 8);
        chk("t3_wait_ack_state", 64'(state[1]), 64'd2);
        chk("t3_ready_low", 64'(s_ready[1]), 64'd0);
        repeat (4) @(posedge clk);
        #1 img_ack[1] = 1'b1;
        @(posedge clk); #1 img_ack[1] = 1'b0;
        ack_cyc = cyc;
        wait_writes(1, base + 9);
        chk("t3_resume_after_ack", 64'(last_wr_cyc[1] >= ack_cyc + 1), 64'd1);
        wait_writes(1, base + 16);
        chk("t3_done", 64'(done[1]), 64'd1);
      end
    join
    chk("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // T4: early acks give credit; the second one overflows
    base = wr_cnt[1];
    pulse_start(1);
    fork
      drive(1, 16, 4, 2);
      begin
        wait_writes(1, base + 2);
        pulse_ack(1);
        chk("t4_first_ack_no_ovf", 64'(ack_ovf[1]), 64'd0);
        pulse_ack(1);
        chk("t4_second_ack_ovf", 64'(ack_ovf[1]), 64'd1);
        wait_writes(1, base + 8);
        eof_cyc = last_wr_cyc[1];
        chk("t4_no_stall_state", 64'(state[1]), 64'd1);
        wait_writes(1, base + 9);
        chk("t4_next_image_gap", 64'(last_wr_cyc[1] - eof_cyc), 64'd2);
        wait_writes(1, base + 16);
        chk("t4_done_ovf_sticky", 64'({done[1], ack_ovf[1]}), 64'b11);
      end
    join
    chk("t4_queue_drained", 64'(exp_q.size()), 64'd0);

    // T5: reset mid-image, then a clean run
    base = wr_cnt[0];
    pulse_start(0);
    fork
      drive(0, 8, 4, 2);
      begin
        wait_writes(0, base + 3);
        rst[0] = 1'b1;
        #1;
        chk("t5_reset_outputs", outs(0), 64'd0);
        abort_drv = 1'b1;
      end
    join
    exp_q.delete();
    abort_drv = 1'b0;
    @(posedge clk); #1 rst[0] = 1'b0;
    base = wr_cnt[0];
    pulse_start(0);
    drive(0, 8, 4, 2);
    wait_writes(0, base + 8);
    chk("t5_done_after_restart", 64'(done[0]), 64'd1);
    chk("t5_queue_drained", 64'(exp_q.size()), 64'd0);

    // T6: 1x1 frames, three images
    base = wr_cnt[2];
    pulse_start(2);
    drive(2, 3, 1, 1);
    wait_writes(2, base + 3);
    chk("t6_done_not_busy", 64'({busy[2], done[2]}), 64'b01);
    chk("t6_queue_drained", 64'(exp_q.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
